// File: rtl/q_op_timing_queue.sv
// q_op_timing_queue
//   Timed issue buffer placed after the quantum register decoder. Incoming
//   220-bit qubit operation vectors are queued together with a relative wait
//   and their end-of-sequence flag. Each vector is then released as a
//   one-cycle fire strobe, spaced from the previous fire by (wait + 1) cycles.
//   The block also flags timeline breaks (underrun) and counts fires.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   op_valid     upstream offers an op vector
//   op_ready     queue can accept (not full); depends on occupancy only
//   op_vec       220-bit qubit op vector
//   op_wait      gap W: this op fires W+1 cycles after the previous fire
//   op_last      final op of a sequence; an empty queue after it is not an underrun
//   run_en       1 = timeline runs, 0 = countdown and issue frozen
//   flush        drop all queued ops and return to idle
//   clear_err    clear the sticky underrun flag
//   q_fire_valid registered one-cycle fire strobe
//   q_fire_vec   registered issued vector; holds its value between fires
//   underrun     sticky: a non-last op fired and left the queue empty
//   fire_cnt     fires since reset/flush, wraps at 2^16
//   level        current FIFO occupancy
module q_op_timing_queue #(
  parameter int DEPTH  = 4,
  parameter int WAIT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [219:0]               op_vec,
  input  logic [WAIT_W-1:0]          op_wait,
  input  logic                       op_last,
  input  logic                       run_en,
  input  logic                       flush,
  input  logic                       clear_err,
  output logic                       q_fire_valid,
  output logic [219:0]               q_fire_vec,
  output logic                       underrun,
  output logic [15:0]                fire_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  // Queue storage: vector, wait and last flag share one write pointer.
  logic [219:0]      mem_vec_q  [DEPTH];
  logic [WAIT_W-1:0] mem_wait_q [DEPTH];
  logic              mem_last_q [DEPTH];

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              fire_valid_q, fire_valid_d;
  logic [219:0]      fire_vec_q, fire_vec_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       fire_cnt_q, fire_cnt_d;

  logic              push, pop;
  logic [AW-1:0]     rd_next;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign rd_next  = rd_ptr_q + AW'(1);
  assign op_ready = (level_q != LW'(DEPTH));

  always_comb begin
    push         = op_valid && op_ready && !flush;
    pop          = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    fire_valid_d = 1'b0;
    fire_vec_d   = fire_vec_q;
    fire_cnt_d   = fire_cnt_q;
    // A fire that sets underrun later in this block overrides the clear.
    underrun_d   = underrun_q & ~clear_err;

    if (flush) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      fire_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Uses the registered level, so a same-cycle push is seen next cycle.
          if (run_en && level_q != '0) begin
            cnt_d   = mem_wait_q[rd_ptr_q];
            state_d = S_COUNT;
          end
        end
        S_COUNT: begin
          if (run_en) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - WAIT_W'(1);
            end else begin
              pop          = 1'b1;
              fire_valid_d = 1'b1;
              fire_vec_d   = mem_vec_q[rd_ptr_q];
              fire_cnt_d   = fire_cnt_q + 16'd1;
              // Chain straight into the next entry so spacing stays W+1.
              if (level_q >= LW'(2)) begin
                cnt_d = mem_wait_q[rd_next];
              end else begin
                state_d = S_IDLE;
                if (!mem_last_q[rd_ptr_q]) underrun_d = 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_next;
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      fire_valid_q <= 1'b0;
      fire_vec_q   <= '0;
      underrun_q   <= 1'b0;
      fire_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      fire_valid_q <= fire_valid_d;
      fire_vec_q   <= fire_vec_d;
      underrun_q   <= underrun_d;
      fire_cnt_q   <= fire_cnt_d;
    end
  end

  // Storage is not reset: contents are only ever read behind a valid level.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_vec_q[wr_ptr_q]  <= op_vec;
      mem_wait_q[wr_ptr_q] <= op_wait;
      mem_last_q[wr_ptr_q] <= op_last;
    end
  end

  assign q_fire_valid = fire_valid_q;
  assign q_fire_vec   = fire_vec_q;
  assign underrun     = underrun_q;
  assign fire_cnt     = fire_cnt_q;
  assign level        = level_q;

endmodule

// File: tb/tb_q_op_timing_queue.sv
// Self-checking bench for q_op_timing_queue: a table of single-op cold starts
// plus hand-written sequences for chaining, backpressure, freeze, flush and
// reset. Inputs change and outputs are sampled 1 time unit after each edge.
module tb_q_op_timing_queue;

  localparam int DEPTH  = 4;
  localparam int WAIT_W = 16;
  localparam int VW     = 220;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, op_valid, op_last, run_en, flush, clear_err;
  logic [VW-1:0]     op_vec;
  logic [WAIT_W-1:0] op_wait;
  logic              op_ready, q_fire_valid, underrun;
  logic [VW-1:0]     q_fire_vec;
  logic [15:0]       fire_cnt;
  logic [LW-1:0]     level;

  q_op_timing_queue #(.DEPTH(DEPTH), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_vec(op_vec), .op_wait(op_wait), .op_last(op_last), .run_en(run_en),
    .flush(flush), .clear_err(clear_err), .q_fire_valid(q_fire_valid),
    .q_fire_vec(q_fire_vec), .underrun(underrun), .fire_cnt(fire_cnt),
    .level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [VW-1:0]     vec;
    logic [WAIT_W-1:0] wt;
    logic              last;
    int                exp_lat;  // edges from handshake edge to the edge raising the strobe
    logic              exp_und;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [VW-1:0] v, input logic [WAIT_W-1:0] w, input logic l);
    op_valid = 1'b1; op_vec = v; op_wait = w; op_last = l;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Ticks until the strobe is seen; lat = -1 if the budget runs out.
  task automatic wait_fire(output int lat, input int budget);
    int n;
    lat = -1;
    n = 0;
    while (lat < 0 && n < budget) begin
      n++;
      tick();
      if (q_fire_valid) lat = n;
    end
  endtask

  initial begin
    logic [VW-1:0] va, vb, vc, vd, vf, vg, vh;
    logic [VW-1:0] seen_vec [4];
    int seen_t [4];
    int k, lat, nf;

    va = {110{2'b11}};
    vb = {110{2'b10}};
    vc = {55{4'b0110}};
    vd = {110{2'b01}};
    vf = {55{4'b1100}};
    vg = {22{10'b1101001110}};
    vh = {44{5'b10011}};

    tbl[0] = '{vec: va, wt: 16'd3, last: 1'b1, exp_lat: 5,  exp_und: 1'b0};
    tbl[1] = '{vec: vb, wt: 16'd0, last: 1'b1, exp_lat: 2,  exp_und: 1'b0};
    tbl[2] = '{vec: vc, wt: 16'd7, last: 1'b0, exp_lat: 9,  exp_und: 1'b1};
    tbl[3] = '{vec: vd, wt: 16'd1, last: 1'b0, exp_lat: 3,  exp_und: 1'b1};

    rst = 1'b1; op_valid = 1'b0; op_last = 1'b0; run_en = 1'b0;
    flush = 1'b0; clear_err = 1'b0; op_vec = '0; op_wait = '0;
    tick(); tick();
    chk("rst_op_ready", VW'(op_ready), VW'(1));
    chk("rst_fire_valid", VW'(q_fire_valid), VW'(0));
    chk("rst_fire_vec", q_fire_vec, '0);
    chk("rst_underrun", VW'(underrun), VW'(0));
    chk("rst_fire_cnt", VW'(fire_cnt), VW'(0));
    chk("rst_level", VW'(level), VW'(0));
    rst = 1'b0;
    tick();

    // Table: cold start of a single op from an empty, idle queue.
    for (int i = 0; i < 4; i++) begin
      do_flush();
      clear_err = 1'b1; tick(); clear_err = 1'b0;
      chk("tbl_underrun_cleared", VW'(underrun), VW'(0));
      run_en = 1'b1;
      push(tbl[i].vec, tbl[i].wt, tbl[i].last);
      wait_fire(lat, int'(tbl[i].wt) + 12);
      $display("vec %0d: wait=%0d last=%0d latency=%0d", i, tbl[i].wt, tbl[i].last, lat);
      chk("tbl_latency", VW'(lat), VW'(tbl[i].exp_lat));
      chk("tbl_fire_vec", q_fire_vec, tbl[i].vec);
      chk("tbl_fire_cnt", VW'(fire_cnt), VW'(1));
      chk("tbl_level", VW'(level), VW'(0));
      tick();
      chk("tbl_strobe_one_cycle", VW'(q_fire_valid), VW'(0));
      chk("tbl_underrun", VW'(underrun), VW'(tbl[i].exp_und));
      tick(); tick(); tick();
      chk("tbl_underrun_sticky", VW'(underrun), VW'(tbl[i].exp_und));
      chk("tbl_vec_held", q_fire_vec, tbl[i].vec);
      run_en = 1'b0;
    end
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("clear_err", VW'(underrun), VW'(0));

    // Back-to-back chain: waits 0,0,2,1 preloaded, then run_en rises.
    do_flush();
    push(va, 16'd0, 1'b0);
    push(vb, 16'd0, 1'b0);
    push(vc, 16'd2, 1'b0);
    push(vd, 16'd1, 1'b1);
    chk("b2b_level_full", VW'(level), VW'(4));
    chk("b2b_ready_low", VW'(op_ready), VW'(0));
    run_en = 1'b1;
    k = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (q_fire_valid && k < 4) begin
        seen_t[k] = t; seen_vec[k] = q_fire_vec; k++;
        $display("b2b fire %0d at t=%0d", k - 1, t);
      end
    end
    chk("b2b_fire_count", VW'(k), VW'(4));
    if (k == 4) begin
      chk("b2b_first_t", VW'(seen_t[0]), VW'(2));
      chk("b2b_dt1", VW'(seen_t[1] - seen_t[0]), VW'(1));
      chk("b2b_dt2", VW'(seen_t[2] - seen_t[0]), VW'(4));
      chk("b2b_dt3", VW'(seen_t[3] - seen_t[0]), VW'(6));
      chk("b2b_vec0", seen_vec[0], va);
      chk("b2b_vec1", seen_vec[1], vb);
      chk("b2b_vec2", seen_vec[2], vc);
      chk("b2b_vec3", seen_vec[3], vd);
    end
    chk("b2b_fire_cnt", VW'(fire_cnt), VW'(4));
    chk("b2b_underrun", VW'(underrun), VW'(0));
    run_en = 1'b0;

    // Full / backpressure.
    do_flush();
    push(vd, 16'd1, 1'b0);
    push(vc, 16'd1, 1'b0);
    push(vb, 16'd1, 1'b0);
    push(va, 16'd1, 1'b1);
    chk("full_ready_low", VW'(op_ready), VW'(0));
    chk("full_level", VW'(level), VW'(4));
    push(vf, 16'd1, 1'b1);
    chk("full_5th_rejected", VW'(level), VW'(4));
    run_en = 1'b1;
    k = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (q_fire_valid && k < 4) begin
        seen_vec[k] = q_fire_vec; k++;
        $display("full fire %0d at t=%0d", k - 1, t);
      end
    end
    chk("full_fire_count", VW'(k), VW'(4));
    if (k == 4) begin
      chk("full_vec0", seen_vec[0], vd);
      chk("full_vec3", seen_vec[3], va);
    end
    chk("full_ready_back", VW'(op_ready), VW'(1));
    chk("full_level_empty", VW'(level), VW'(0));
    chk("full_underrun", VW'(underrun), VW'(0));
    run_en = 1'b0;
    push(vf, 16'd1, 1'b1);
    chk("full_5th_accepted", VW'(level), VW'(1));

    // Freeze: wait=5, run_en low for 3 cycles mid-count -> 7 + 3.
    do_flush();
    run_en = 1'b1;
    push(vg, 16'd5, 1'b1);
    nf = 0;
    tick(); tick();
    run_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (q_fire_valid) nf++;
    end
    chk("freeze_no_fire", VW'(nf), VW'(0));
    run_en = 1'b1;
    wait_fire(lat, 20);
    if (lat > 0) lat = lat + 5;
    $display("freeze: latency=%0d", lat);
    chk("freeze_latency", VW'(lat), VW'(10));
    chk("freeze_vec", q_fire_vec, vg);
    chk("freeze_fire_cnt", VW'(fire_cnt), VW'(1));

    // Flush mid-countdown: nothing fires afterwards, vec and underrun kept.
    run_en = 1'b0;
    push(va, 16'd5, 1'b0);
    push(vb, 16'd5, 1'b0);
    push(vh, 16'd5, 1'b1);
    run_en = 1'b1;
    tick(); tick(); tick();
    do_flush();
    chk("flush_level", VW'(level), VW'(0));
    chk("flush_fire_cnt", VW'(fire_cnt), VW'(0));
    chk("flush_ready", VW'(op_ready), VW'(1));
    chk("flush_vec_kept", q_fire_vec, vg);
    chk("flush_underrun_kept", VW'(underrun), VW'(0));
    nf = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (q_fire_valid) nf++;
    end
    chk("flush_no_fire", VW'(nf), VW'(0));
    $display("flush: fires after flush=%0d", nf);

    // Reset mid-countdown after an underrun: everything back to reset values.
    push(vh, 16'd0, 1'b0);
    wait_fire(lat, 10);
    chk("pre_rst_latency", VW'(lat), VW'(2));
    tick();
    chk("pre_rst_underrun", VW'(underrun), VW'(1));
    run_en = 1'b0;
    push(va, 16'd5, 1'b0);
    push(vb, 16'd5, 1'b0);
    push(vc, 16'd5, 1'b1);
    run_en = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_op_ready", VW'(op_ready), VW'(1));
    chk("mid_rst_fire_valid", VW'(q_fire_valid), VW'(0));
    chk("mid_rst_fire_vec", q_fire_vec, '0);
    chk("mid_rst_underrun", VW'(underrun), VW'(0));
    chk("mid_rst_fire_cnt", VW'(fire_cnt), VW'(0));
    chk("mid_rst_level", VW'(level), VW'(0));
    nf = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (q_fire_valid) nf++;
    end
    chk("mid_rst_no_fire", VW'(nf), VW'(0));
    $display("reset: fires after reset=%0d", nf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/q_op_timing_queue.md
# q_op_timing_queue

Timed issue buffer sitting directly downstream of the quantum register decoder. It accepts 220-bit qubit operation vectors (110 qubits × 2 bits: 2'b11 single-qubit op, 2'b10/2'b01 two-qubit control/target, 2'b00 idle), each tagged with a relative wait. It holds them in a small FIFO and releases each vector as a one-cycle fire strobe at a precise cycle spacing to the pulse-generation stage. It also flags timeline breaks (underrun) and counts issued operations.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- WAIT_W, 16, width of the relative wait field and countdown counter
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  upstream has an op vector
- op_ready  out  1  queue can accept; equals !full
- op_vec  in  220  qubit op vector from decoder
- op_wait  in  WAIT_W  gap W: this op fires W+1 cycles after the previous fire
- op_last  in  1  marks final op of a sequence (suppresses underrun)
- run_en  in  1  1 = timeline runs; 0 = freeze countdown and issue
- flush  in  1  discard all queued ops, return to IDLE
- clear_err  in  1  clears sticky underrun
- q_fire_valid  out  1  one-cycle strobe, registered
- q_fire_vec  out  220  op vector being issued, registered; holds last value when strobe low
- underrun  out  1  sticky: a non-last op fired and left the queue empty
- fire_cnt  out  16  number of fires since reset/flush, wraps at 2^16
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO entry = {op_last, op_wait, op_vec}. Push when op_valid && op_ready. No push when full, even if a pop occurs in the same cycle.
- FSM states are IDLE and COUNT. cnt is a WAIT_W-bit register.
- IDLE: if run_en && level≠0, load cnt ← head.wait and go to COUNT. A push in the same cycle is not visible until the next cycle.
- COUNT, run_en=0: hold cnt and state; no fire.
- COUNT, run_en=1, cnt≠0: cnt ← cnt−1.
- COUNT, run_en=1, cnt==0, which is the fire cycle:
  - Next edge: q_fire_valid←1, q_fire_vec←head.vec, pop head, fire_cnt←fire_cnt+1.
  - If level≥2 (excluding any same-cycle push): cnt←next.wait, stay in COUNT.
  - Otherwise go to IDLE. If head.last==0, set underrun←1.
- q_fire_valid is 0 in every cycle that is not immediately after a fire cycle.
- flush (priority over push, pop and fire):
  - Next edge: level←0, state←IDLE, cnt←0, fire_cnt←0, q_fire_valid←0.
  - q_fire_vec and underrun are untouched.
  - A push in a flush cycle is dropped, but op_ready still reflects the pre-flush state.
- clear_err: underrun←0 at next edge. If an underrun-setting fire occurs in the same cycle, set wins.
- Wait arithmetic is unsigned. W=0 gives back-to-back fires. W=2^WAIT_W−1 gives the maximum gap of 2^WAIT_W cycles.
- rst forces everything to its reset value, including mid-countdown.
- Reset values: op_ready=1, q_fire_valid=0, q_fire_vec=0, underrun=0, fire_cnt=0, level=0, state IDLE, cnt=0.

## Timing
- Cold-start latency: the op is accepted at the edge ending cycle 0 with the queue empty, state IDLE and run_en=1. q_fire_valid is high in cycle W+2, i.e. W+2 cycles after the handshake cycle.
- Steady-state spacing: with the next op already queued, fire-to-fire distance is exactly W+1 cycles, where W is the later op's wait.
- run_en low for k cycles during COUNT delays the pending fire by exactly k cycles.
- op_ready is combinational from level only, with no path from op_valid.
- q_fire_vec changes only on fire edges, flush aside.

## Test plan
- Cold start, single op: vec=all 2'b11, wait=3, last=1, run_en=1 → q_fire_valid high for one cycle 5 cycles after the handshake; fire_cnt=1; underrun=0; state IDLE.
- Back-to-back: 4 ops with waits 0,0,2,1, vecs A,B,C,D, preloaded before run_en rises → fires in order A,B,C,D at relative cycles t, t+1, t+4, t+6.
- Full/backpressure: push 5 ops with run_en=0 → op_ready=0 after 4, level=4, 5th not accepted; raise run_en → 4 fires, then op_ready=1 and the 5th can be pushed.
- Freeze: wait=5, drop run_en for 3 cycles mid-count → fire is 3 cycles later than the unfrozen case.
- Underrun: single op with last=0 fires → underrun=1 and stays set; clear_err → 0. Repeat with last=1 → underrun stays 0.
- Flush/reset mid-operation: 3 queued, cnt mid-count, assert flush → no fire ever, level=0, fire_cnt=0, op_ready=1. Same scenario with rst → all outputs at reset values, including q_fire_vec=0.
